game_round_ctrl: RTL and testbench
==================================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 500000: clk cycles per game tick.
REQ-002 Parameter START_DELAY, default 120: countdown length in ticks.
REQ-003 Parameter ROUND_TICKS, default 3600: ticks player 1 must survive to win a round.
REQ-004 Parameter HOLD_TICKS, default 60: post-round freeze in ticks.
REQ-005 Parameter HIT_DIST, default 32: catch distance in pixels, per axis.
REQ-006 Parameter WIN_SCORE, default 5: score that ends the game.
REQ-007 clk  in  1  system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 start  in  1  level button; its rising edge is the start/restart command.
REQ-010 pause  in  1  level button; its rising edge toggles pause (see Configuration).
REQ-011 p1_x, p1_y, p2_x, p2_y  in  10 each  current player centre positions.
REQ-012 move_tick  out  1  one-cycle movement-enable pulse to both player drawers.
REQ-013 pos_load  out  1  one-cycle pulse commanding both players to reload spawn positions.
REQ-014 state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, ROUND_END=3, GAME_OVER=4.
REQ-015 score_p1, score_p2  out  4 each  round wins.
REQ-016 game_over  out  1  high exactly while state is GAME_OVER.

Function
REQ-017 The tick counter SHALL run 0..TICK_DIV-1 in every state; tick is asserted for the one cycle when the count equals TICK_DIV-1.
REQ-018 The start and pause edges SHALL each be detected against a one-cycle registered copy of the input.
REQ-019 IDLE: on a start edge, the block SHALL clear both scores, pulse pos_load, clear the phase counter, and enter COUNTDOWN.
REQ-020 COUNTDOWN: the phase counter SHALL increment on each tick; at START_DELAY ticks it SHALL clear and the block SHALL enter PLAY.
REQ-021 PLAY: move_tick SHALL equal tick; all other states SHALL hold move_tick at 0.
REQ-022 Overlap SHALL be |p1_x-p2_x| < HIT_DIST and |p1_y-p2_y| < HIT_DIST, using unsigned absolute difference with no wrap.
REQ-023 PLAY, on overlap: score_p2 SHALL increment and the block SHALL enter ROUND_END next cycle.
REQ-024 PLAY, when the phase counter reaches ROUND_TICKS ticks: score_p1 SHALL increment and the block SHALL enter ROUND_END.
REQ-025 If overlap and round expiry occur in the same cycle, overlap SHALL win: only score_p2 increments.
REQ-026 Scores SHALL saturate at 15 and SHALL never wrap.
REQ-027 ROUND_END: after HOLD_TICKS ticks, if either score is at least WIN_SCORE the block SHALL enter GAME_OVER; otherwise it SHALL pulse pos_load and enter COUNTDOWN.
REQ-028 GAME_OVER: scores SHALL be held; on a start edge the block SHALL enter IDLE.
REQ-029 A start edge outside IDLE and GAME_OVER SHALL be ignored.
REQ-030 Every state entry SHALL clear the phase counter.
REQ-031 pos_load and move_tick SHALL be registered outputs and SHALL never assert in the same cycle.

Reset
REQ-032 While rst=0 on a clock edge: state=IDLE; tick counter, phase counter, scores, move_tick, pos_load, game_over and the paused flag SHALL all be 0.
REQ-033 Edge-detect registers SHALL reset to 0, so a start held high through reset release SHALL produce one edge.
REQ-034 Reset asserted mid-round SHALL abandon the round with no score update.

Configuration
REQ-035 With macro GAME_PAUSE_EN defined, a pause edge in PLAY SHALL toggle the paused flag.
REQ-036 While paused: move_tick=0, the phase counter is frozen, and overlap is ignored; leaving PLAY clears paused.
REQ-037 Without GAME_PAUSE_EN, the pause port SHALL exist but be ignored, and no paused flag SHALL be implemented.

Verification (TICK_DIV=4, START_DELAY=2, ROUND_TICKS=5, HOLD_TICKS=1, WIN_SCORE=2)
REQ-038 Start pulse in IDLE -> pos_load pulse the next cycle, state=1, and state=2 after 2 ticks; move_tick period is 4 cycles.
REQ-039 PLAY with p1=(100,100), p2=(131,100) -> overlap, score_p2=1, state=3; with p2=(132,100) -> no catch.
REQ-040 PLAY without overlap for 5 ticks -> score_p1=1, ROUND_END, then pos_load and COUNTDOWN.
REQ-041 Overlap in the same cycle as round expiry -> only score_p2 increments.
REQ-042 Two player-2 catches -> GAME_OVER with game_over=1; start edge -> IDLE; a further start edge clears scores.
REQ-043 With GAME_PAUSE_EN: pause edge in PLAY -> no move_tick and no catch while overlapping; second pause edge -> resumes with the phase counter unchanged.

Source files
------------

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round/score sequencer for a two-player chase game
// Optional pause support is built in when GAME_PAUSE_EN is defined.
module game_round_ctrl #(
    parameter int unsigned TICK_DIV    = 500000,
    parameter int unsigned START_DELAY = 120,
    parameter int unsigned ROUND_TICKS = 3600,
    parameter int unsigned HOLD_TICKS  = 60,
    parameter int unsigned HIT_DIST    = 32,
    parameter int unsigned WIN_SCORE   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    output logic       move_tick,
    output logic       pos_load,
    output logic [2:0] state,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_ROUND_END = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PMAX_A = (START_DELAY > ROUND_TICKS) ? START_DELAY : ROUND_TICKS;
    localparam int unsigned PMAX   = (PMAX_A > HOLD_TICKS) ? PMAX_A : HOLD_TICKS;
    localparam int PW = (PMAX > 1) ? $clog2(PMAX + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] START_LAST = PW'(START_DELAY - 1);
    localparam logic [PW-1:0] ROUND_LAST = PW'(ROUND_TICKS - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_TICKS - 1);
    localparam logic [10:0]   HIT_LIM    = 11'(HIT_DIST);
    localparam logic [4:0]    WIN_LIM    = 5'(WIN_SCORE);

    state_t        state_q, state_n;
    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] phase_q, phase_n;
    logic [3:0]    score1_n, score2_n;
    logic          pos_load_n, move_tick_n;
    logic          tick, start_q, start_edge, run;
    logic [9:0]    dx, dy;
    logic          overlap;

`ifdef GAME_PAUSE_EN
    logic pause_q, pause_edge, paused, paused_n;
    assign pause_edge = pause & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = pause;
`endif

    assign tick       = (tick_cnt == TICK_LAST);
    assign start_edge = start & ~start_q;

    // Unsigned distance per axis; subtract the smaller from the larger so nothing wraps.
    assign dx      = (p1_x >= p2_x) ? p1_x - p2_x : p2_x - p1_x;
    assign dy      = (p1_y >= p2_y) ? p1_y - p2_y : p2_y - p1_y;
    assign overlap = ({1'b0, dx} < HIT_LIM) && ({1'b0, dy} < HIT_LIM);

    always_comb begin
        state_n    = state_q;
        phase_n    = phase_q;
        score1_n   = score_p1;
        score2_n   = score_p2;
        pos_load_n = 1'b0;
        run        = 1'b1;
`ifdef GAME_PAUSE_EN
        paused_n   = paused;
        run        = !paused;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    score1_n   = 4'd0;
                    score2_n   = 4'd0;
                    pos_load_n = 1'b1;
                    phase_n    = '0;
                    state_n    = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (phase_q == START_LAST) begin
                        phase_n = '0;
                        state_n = S_PLAY;
                    end else begin
                        phase_n = phase_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
`ifdef GAME_PAUSE_EN
                if (pause_edge) paused_n = !paused;
`endif
                // A catch outranks round expiry when both land in the same cycle.
                if (run) begin
                    if (overlap) begin
                        score2_n = (score_p2 == 4'hF) ? score_p2 : score_p2 + 4'd1;
                        phase_n  = '0;
                        state_n  = S_ROUND_END;
                    end else if (tick) begin
                        if (phase_q == ROUND_LAST) begin
                            score1_n = (score_p1 == 4'hF) ? score_p1 : score_p1 + 4'd1;
                            phase_n  = '0;
                            state_n  = S_ROUND_END;
                        end else begin
                            phase_n = phase_q + 1'b1;
                        end
                    end
                end
            end
            S_ROUND_END: begin
                if (tick) begin
                    if (phase_q == HOLD_LAST) begin
                        phase_n = '0;
                        if (({1'b0, score_p1} >= WIN_LIM) || ({1'b0, score_p2} >= WIN_LIM)) begin
                            state_n = S_GAME_OVER;
                        end else begin
                            pos_load_n = 1'b1;
                            state_n    = S_COUNTDOWN;
                        end
                    end else begin
                        phase_n = phase_q + 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                if (start_edge) begin
                    phase_n = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                phase_n = '0;
                state_n = S_IDLE;
            end
        endcase
        // move_tick is registered; gate on the next state so it only shows while state reads PLAY.
`ifdef GAME_PAUSE_EN
        if (state_n != S_PLAY) paused_n = 1'b0;
        move_tick_n = tick && (state_q == S_PLAY) && (state_n == S_PLAY) && !paused_n;
`else
        move_tick_n = tick && (state_q == S_PLAY) && (state_n == S_PLAY);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tick_cnt  <= '0;
            phase_q   <= '0;
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            move_tick <= 1'b0;
            pos_load  <= 1'b0;
            game_over <= 1'b0;
            start_q   <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_q   <= 1'b0;
            paused    <= 1'b0;
`endif
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            state_q   <= state_n;
            phase_q   <= phase_n;
            score_p1  <= score1_n;
            score_p2  <= score2_n;
            move_tick <= move_tick_n;
            pos_load  <= pos_load_n;
            game_over <= (state_n == S_GAME_OVER);
            start_q   <= start;
`ifdef GAME_PAUSE_EN
            pause_q   <= pause;
            paused    <= paused_n;
`endif
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - directed self-checking bench for game_round_ctrl
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, pause;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       move_tick, pos_load, game_over;
    logic [2:0] state;
    logic [3:0] score_p1, score_p2;

    int checks = 0;
    int errors = 0;
    int mt_cnt = 0;
    int viol   = 0;
    int n, m;

    game_round_ctrl #(
        .TICK_DIV(4), .START_DELAY(2), .ROUND_TICKS(5),
        .HOLD_TICKS(1), .HIT_DIST(32), .WIN_SCORE(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .move_tick(move_tick), .pos_load(pos_load), .state(state),
        .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (move_tick && pos_load) viol++;
            if (move_tick && state != 3'd2) viol++;
            if (game_over != (state == 3'd4)) viol++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (move_tick) mt_cnt++;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget, output int cnt);
        cnt = 0;
        while (state != s && cnt < budget) begin
            step();
            cnt++;
        end
        if (state != s) check(tag, int'(state), int'(s));
    endtask

    task automatic set_p2(input int x, input int y);
        p2_x = 10'(x);
        p2_y = 10'(y);
    endtask

    typedef struct { int x; int y; } pos_t;
    pos_t miss_tab[4] = '{'{132, 100}, '{100, 132}, '{131, 132}, '{68, 100}};

    initial begin
        rst = 1'b0; start = 1'b0; pause = 1'b0;
        p1_x = 10'd100; p1_y = 10'd100;
        set_p2(500, 500);
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_score_p1", score_p1, 0);
        check("rst_score_p2", score_p2, 0);
        check("rst_move_tick", move_tick, 0);
        check("rst_pos_load", pos_load, 0);
        check("rst_game_over", game_over, 0);

        // start held high across reset release must still register one edge
        start = 1'b1; rst = 1'b1;
        step();
        check("start_state", state, 1);
        check("start_pos_load", pos_load, 1);
        start = 1'b0;
        wait_state("to_play1", 3'd2, 30, n);
        check("countdown_cycles", n, 7);
        check("countdown_pos_load_drop", pos_load, 0);

        n = 0;
        while (!move_tick && n < 10) begin step(); n++; end
        check("first_move_tick", n, 4);
        m = 0;
        do begin step(); m++; end while (!move_tick && m < 10);
        check("move_tick_period", m, 4);
        wait_state("to_round_end1", 3'd3, 30, n);
        check("round_len", n + 8, 20);
        check("expiry_score_p1", score_p1, 1);
        check("expiry_score_p2", score_p2, 0);
        wait_state("to_countdown2", 3'd1, 20, n);
        check("hold_cycles", n, 4);
        check("reload_pos_load", pos_load, 1);

        start = 1'b1;
        step();
        check("start_ignored", state, 1);
        start = 1'b0;
        wait_state("to_play2", 3'd2, 30, n);
        foreach (miss_tab[i]) begin
            set_p2(miss_tab[i].x, miss_tab[i].y);
            step();
            check($sformatf("no_catch_%0d", i), state, 2);
        end
        set_p2(131, 100);
        step();
        check("catch_state", state, 3);
        check("catch_score_p2", score_p2, 1);
        check("catch_score_p1", score_p1, 1);

        set_p2(500, 500);
        wait_state("to_countdown3", 3'd1, 20, n);
        wait_state("to_play3", 3'd2, 30, n);
        repeat (19) step();
        check("pre_expiry_state", state, 2);
        set_p2(131, 100);
        step();
        check("tie_state", state, 3);
        check("tie_score_p2", score_p2, 2);
        check("tie_score_p1", score_p1, 1);

        wait_state("to_game_over", 3'd4, 20, n);
        check("go_flag", game_over, 1);
        repeat (5) step();
        check("go_hold_state", state, 4);
        check("go_hold_p1", score_p1, 1);
        check("go_hold_p2", score_p2, 2);
        start = 1'b1;
        step();
        check("go_to_idle", state, 0);
        check("idle_go_flag", game_over, 0);
        check("idle_keeps_p2", score_p2, 2);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check("restart_state", state, 1);
        check("restart_p1", score_p1, 0);
        check("restart_p2", score_p2, 0);
        start = 1'b0;

        set_p2(500, 500);
        wait_state("to_play4", 3'd2, 30, n);
        set_p2(131, 100);
        rst = 1'b0;
        step();
        check("midrst_state", state, 0);
        check("midrst_p2", score_p2, 0);
        check("midrst_p1", score_p1, 0);
        step();
        rst = 1'b1;
        set_p2(500, 500);
        start = 1'b1;
        step();
        check("post_rst_start", state, 1);
        start = 1'b0;
        wait_state("to_play5", 3'd2, 30, n);

`ifdef GAME_PAUSE_EN
        mt_cnt = 0;
        pause = 1'b1;
        step();
        pause = 1'b0;
        set_p2(131, 100);
        repeat (11) step();
        check("paused_no_catch", state, 2);
        check("paused_score_p2", score_p2, 0);
        check("paused_move_tick", mt_cnt, 0);
        set_p2(500, 500);
        pause = 1'b1;
        step();
        pause = 1'b0;
        wait_state("to_round_end_pause", 3'd3, 40, n);
        check("paused_round_len", n + 13, 32);
        check("paused_expiry_p1", score_p1, 1);
`else
        pause = 1'b1;
        step();
        pause = 1'b0;
        wait_state("to_round_end_nopause", 3'd3, 40, n);
        check("pause_ignored_len", n + 1, 20);
        check("pause_ignored_p1", score_p1, 1);
`endif

        check("output_invariants", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
